mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single backing-memory port between the icache refill path and the data-side load/store path.
- Sequences one memory transaction at a time and latches address and data at grant.
- Returns read data together with a one-cycle valid pulse. The instruction-side pulse drives the icache `fetch` input directly and its data drives the icache `write_data` input.
- Sits between icache/dcache and the memory wrapper (SPRAM or external RAM). The memory side uses a request/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 255, busy cycles without mem_ready before the transaction is aborted (1..255).
- IPRIO_DEFAULT, 1, requester that wins a simultaneous first request after reset (1 = instruction, 0 = data).

Ports:
- CLK  input  1  clock; everything is clocked on the rising edge
- resetn  input  1  synchronous reset, active-low
- i_req  input  1  instruction refill request; level, held until i_valid
- i_addr  input  20  instruction byte address; bits [1:0] ignored
- i_valid  output  1  one-cycle pulse; i_rdata is valid in that cycle
- i_rdata  output  32  refill word
- d_req  input  1  data request; level, held until d_valid
- d_we  input  1  1 = write, 0 = read
- d_addr  input  20  data byte address; bits [1:0] ignored
- d_wdata  input  32  write data
- d_wmask  input  4  byte enables for writes; bit n enables byte n
- d_valid  output  1  one-cycle pulse; read data valid, or write complete
- d_rdata  output  32  read data
- bus_err  output  1  one-cycle pulse, coincident with an aborting i_valid/d_valid
- mem_en  output  1  memory request, held high for the whole transaction
- mem_we  output  1  memory write strobe
- mem_addr  output  18  word address, equal to the latched addr[19:2]
- mem_wdata  output  32  latched write data
- mem_wmask  output  4  latched byte mask; 0 for reads
- mem_rdata  input  32  memory read data, valid when mem_ready = 1
- mem_ready  input  1  memory completes the transaction in this cycle

Behaviour:
- Reset (resetn = 0 at a clock edge):
  - state goes to IDLE.
  - last_grant is set to the value that makes IPRIO_DEFAULT win.
  - mem_en, mem_we, i_valid, d_valid and bus_err go to 0.
  - mem_addr, mem_wdata, mem_wmask, i_rdata and d_rdata go to 0.
  - timeout counter goes to 0.
- Reset mid-transaction drops mem_en in the next cycle and produces no valid pulse. Requesters re-issue their requests.
- State machine:
  - IDLE, only d_req: go to D_BUSY.
  - IDLE, only i_req: go to I_BUSY.
  - IDLE, both requests: grant the requester that was not granted last (round-robin, one bit last_grant).
  - IDLE, no request: stay in IDLE.
  - On grant, latch address, d_we, wdata and wmask. Assert mem_en from the first cycle of the busy state.
  - I_BUSY/D_BUSY with mem_ready = 1: pulse the matching valid for one cycle. For reads, rdata takes the value of mem_rdata captured in that cycle. Deassert mem_en and return to IDLE.
- Latency: grant edge → mem_en high in the next cycle. mem_ready in cycle N → valid registered in cycle N+1. The earliest new grant is in the cycle after valid. Minimum request-to-valid latency is 3 cycles with single-cycle memory.
- Requesters must deassert req in the cycle after they see valid. If req is still high in IDLE, it is treated as a new request.
- rdata holds its last value until the next completion. i_rdata is written only by instruction transactions, d_rdata only by data reads.
- mem_we = 1 only in D_BUSY with latched d_we = 1. Instruction transactions are always reads with mask 0.
- Timeout:
  - The 8-bit counter increments every busy cycle with mem_ready = 0.
  - On reaching TIMEOUT_CYCLES: pulse the matching valid together with bus_err, force rdata to 32'h00000013 (NOP), drop mem_en and return to IDLE.
  - A mem_ready in the same cycle as the timeout takes precedence; it is a normal completion with no bus_err.
  - The counter clears on entering IDLE.
- A request arriving while busy waits. A request dropped before grant is simply not served. Changes to the inputs after grant have no effect.
- A mem_ready received in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, the block adds outputs perf_igrant[31:0], perf_dgrant[31:0] and perf_stall[31:0]:
  - perf_igrant/perf_dgrant increment on each instruction/data grant.
  - perf_stall increments every cycle a requester has req high but is not granted and not being served.
  - All three are cleared by reset and wrap at 2^32.
- When not defined, these ports and counters do not exist. All other behaviour is identical in both configurations.

Test Plan:
- i_req with i_addr=20'h00104, memory ready on the first busy cycle, mem_rdata=32'h00B70023 → mem_addr=18'h00041, mem_we=0, i_valid pulses exactly 3 cycles after the request with i_rdata=32'h00B70023, d_valid stays 0.
- d_req write with d_addr=20'h00208, d_wdata=32'hDEADBEEF, d_wmask=4'b0011 → mem_we=1, mem_addr=18'h00082, mem_wmask=4'b0011; d_valid pulses; d_rdata is unchanged.
- i_req and d_req both asserted continuously after reset with IPRIO_DEFAULT=1 → grants alternate I, D, I, D; each valid pulse is followed by one IDLE cycle.
- i_req with mem_ready held at 0 and TIMEOUT_CYCLES=4 → after 4 busy cycles, i_valid and bus_err pulse together with i_rdata=32'h00000013; mem_en=0 in the next cycle.
- resetn=0 for one cycle mid-D_BUSY → next cycle mem_en=0, d_valid=0, state IDLE; a re-asserted d_req is granted normally.
- With MEM_ARB_PERF_EN: run 3 instruction and 2 data transactions with overlapping requests → perf_igrant=3, perf_dgrant=2, perf_stall equals the number of waiting cycles counted by the bench.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Round-robin icache/dcache arbiter for a single memory port with timeout abort.
// Optional MEM_ARB_PERF_EN adds grant and stall counters (perf_igrant, perf_dgrant, perf_stall).
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit IPRIO_DEFAULT  = 1'b1
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [19:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [19:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [17:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_igrant,
    output logic [31:0] perf_dgrant,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSN     = 32'h00000013;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        last_grant_q;
    logic [7:0]  tmo_cnt_q;
    logic        i_valid_q, d_valid_q, bus_err_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        mem_en_q, mem_we_q;
    logic [17:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;

    logic can_grant, grant_i, grant_d, finish;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    // The valid cycle blocks grants: requesters still hold req while they see valid.
    always_comb begin
        can_grant = (state_q == IDLE) && !i_valid_q && !d_valid_q;
        grant_i   = can_grant && i_req && (!d_req || !last_grant_q);
        grant_d   = can_grant && d_req && !grant_i;
        finish    = (state_q != IDLE) && (mem_ready || (tmo_cnt_q == TIMEOUT_LAST));
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= ~IPRIO_DEFAULT;
            tmo_cnt_q    <= 8'd0;
            i_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 18'd0;
            mem_wdata_q  <= 32'd0;
            mem_wmask_q  <= 4'd0;
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            bus_err_q <= 1'b0;
            if (grant_i || grant_d) begin
                state_q      <= grant_i ? I_BUSY : D_BUSY;
                last_grant_q <= grant_i;
                tmo_cnt_q    <= 8'd0;
                mem_en_q     <= 1'b1;
                mem_we_q     <= grant_d && d_we;
                mem_addr_q   <= grant_i ? i_addr[19:2] : d_addr[19:2];
                mem_wdata_q  <= grant_d ? d_wdata : 32'd0;
                mem_wmask_q  <= (grant_d && d_we) ? d_wmask : 4'd0;
            end else if (finish) begin
                // mem_ready wins over a simultaneous timeout
                state_q   <= IDLE;
                tmo_cnt_q <= 8'd0;
                mem_en_q  <= 1'b0;
                mem_we_q  <= 1'b0;
                bus_err_q <= !mem_ready;
                if (state_q == I_BUSY) begin
                    i_valid_q <= 1'b1;
                    i_rdata_q <= mem_ready ? mem_rdata : NOP_INSN;
                end else begin
                    d_valid_q <= 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_q <= mem_ready ? mem_rdata : NOP_INSN;
                    end
                end
            end else if (state_q != IDLE) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
        end
    end

    assign i_valid   = i_valid_q;
    assign i_rdata   = i_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_igrant_q, perf_dgrant_q, perf_stall_q;
    logic        i_stall, d_stall;

    // A requester is stalled when neither granted, busy for it, nor receiving its valid.
    always_comb begin
        i_stall = i_req && !grant_i && (state_q != I_BUSY) && !i_valid_q;
        d_stall = d_req && !grant_d && (state_q != D_BUSY) && !d_valid_q;
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            perf_igrant_q <= 32'd0;
            perf_dgrant_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            perf_igrant_q <= perf_igrant_q + {31'd0, grant_i};
            perf_dgrant_q <= perf_dgrant_q + {31'd0, grant_d};
            perf_stall_q  <= perf_stall_q + {31'd0, i_stall} + {31'd0, d_stall};
        end
    end

    assign perf_igrant = perf_igrant_q;
    assign perf_dgrant = perf_dgrant_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES=4).
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        resetn;
    logic        i_req, d_req, d_we;
    logic [19:0] i_addr, d_addr;
    logic [31:0] d_wdata, mem_rdata;
    logic [3:0]  d_wmask;
    logic        i_valid, d_valid, bus_err;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        ready_en, ready_force;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_igrant, perf_dgrant, perf_stall;
    int          i_rem, d_rem;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    // Memory responds in the first busy cycle when ready_en is set.
    assign mem_ready = (mem_en & ready_en) | ready_force;

    mem_arbiter #(.TIMEOUT_CYCLES(4), .IPRIO_DEFAULT(1'b1)) dut (
        .CLK(CLK), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_valid(d_valid), .d_rdata(d_rdata),
        .bus_err(bus_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef MEM_ARB_PERF_EN
        , .perf_igrant(perf_igrant), .perf_dgrant(perf_dgrant), .perf_stall(perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int          phase, side;
        logic [20:0] e;
        resetn = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 20'd0; d_addr = 20'd0; d_wdata = 32'd0; d_wmask = 4'd0;
        mem_rdata = 32'd0; ready_en = 1'b0; ready_force = 1'b0;
        step(); step();
        check("rst_ctl", 64'({mem_en, mem_we, i_valid, d_valid, bus_err}), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_wmask", 64'(mem_wmask), 64'(0));
        check("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
        resetn = 1'b1;
        step();

        ready_force = 1'b1;
        step();
        ready_force = 1'b0;
        check("idle_ready_ignored", 64'({i_valid, d_valid, bus_err, mem_en}), 64'(0));

        // Instruction read, single-cycle memory: request cycle 1, busy cycle 2, valid cycle 3
        ready_en = 1'b1; mem_rdata = 32'h00B70023; i_addr = 20'h00104; i_req = 1'b1;
        step();
        check("i_busy", 64'({mem_en, mem_we, i_valid}), 64'(3'b100));
        check("i_addr", 64'(mem_addr), 64'(18'h00041));
        step();
        check("i_valid", 64'({i_valid, d_valid, mem_en}), 64'(3'b100));
        check("i_rdata", 64'(i_rdata), 64'(32'h00B70023));
        step();
        i_req = 1'b0;
        check("i_pulse_once", 64'({i_valid, mem_en}), 64'(0));

        // Data read, then data write that must leave d_rdata alone
        mem_rdata = 32'hCAFEF00D; d_req = 1'b1; d_we = 1'b0; d_addr = 20'h0030C;
        d_wdata = 32'h11111111; d_wmask = 4'hF;
        step();
        check("dr_ctl", 64'({mem_en, mem_we, mem_wmask}), 64'({1'b1, 1'b0, 4'h0}));
        check("dr_addr", 64'(mem_addr), 64'(18'h000C3));
        step();
        check("dr_data", 64'({d_valid, i_valid, d_rdata}), 64'({2'b10, 32'hCAFEF00D}));
        step();
        d_we = 1'b1; d_addr = 20'h00208; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
        mem_rdata = 32'h55AA55AA;
        step();
        check("dw_ctl", 64'({mem_en, mem_we, mem_wmask}), 64'({2'b11, 4'b0011}));
        check("dw_addr", 64'(mem_addr), 64'(18'h00082));
        check("dw_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
        step();
        check("dw_valid", 64'({d_valid, mem_en, mem_we}), 64'(3'b100));
        check("dw_rdata_kept", 64'(d_rdata), 64'(32'hCAFEF00D));
        step();
        d_req = 1'b0; d_we = 1'b0;
        step();
        check("dw_idle", 64'(mem_en), 64'(0));

        // Both requesters held high after reset: I, D, I, D with a 3-cycle period
        resetn = 1'b0;
        step();
        resetn = 1'b1; i_addr = 20'h00400; d_addr = 20'h00800; i_req = 1'b1; d_req = 1'b1;
        for (int c = 2; c <= 13; c++) begin
            step();
            phase = (c - 2) % 3;
            side  = ((c - 2) / 3) % 2;
            e = {phase == 0, (phase == 1) && (side == 0), (phase == 1) && (side == 1),
                 (side == 1) ? 18'h00200 : 18'h00100};
            check($sformatf("alt_c%0d", c), 64'({mem_en, i_valid, d_valid, mem_addr}), 64'(e));
        end
        i_req = 1'b0; d_req = 1'b0;
        step(); step();

        // Timeout with memory never ready: 4 busy cycles then abort
        ready_en = 1'b0; mem_rdata = 32'hFFFFFFFF; i_addr = 20'h00010; i_req = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            step();
            check($sformatf("to_busy_c%0d", c), 64'({mem_en, i_valid, bus_err}), 64'(3'b100));
        end
        step();
        check("to_abort", 64'({i_valid, bus_err, mem_en}), 64'(3'b110));
        check("to_nop", 64'(i_rdata), 64'(32'h00000013));
        step();
        i_req = 1'b0;
        check("to_after", 64'({i_valid, bus_err, mem_en}), 64'(0));
        step();

        // mem_ready arriving in the timeout cycle completes normally
        i_req = 1'b1; mem_rdata = 32'h0000A0B1;
        repeat (4) step();
        ready_en = 1'b1;
        step();
        check("to_race", 64'({i_valid, bus_err}), 64'(2'b10));
        check("to_race_data", 64'(i_rdata), 64'(32'h0000A0B1));
        step();
        i_req = 1'b0;
        step();

        // Reset in the middle of D_BUSY, then a re-issued request
        ready_en = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00020;
        step();
        check("mid_busy", 64'(mem_en), 64'(1));
        step();
        resetn = 1'b0; d_req = 1'b0;
        step();
        check("mid_rst", 64'({mem_en, d_valid, bus_err}), 64'(0));
        resetn = 1'b1;
        step();
        check("mid_idle", 64'({mem_en, d_valid}), 64'(0));
        d_req = 1'b1; ready_en = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        check("rearm_busy", 64'({mem_en, mem_addr}), 64'({1'b1, 18'h00008}));
        step();
        check("rearm_valid", 64'({d_valid, d_rdata}), 64'({1'b1, 32'h0BADF00D}));
        step();
        d_req = 1'b0;
        step();

`ifdef MEM_ARB_PERF_EN
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("perf_rst", 64'(perf_igrant | perf_dgrant | perf_stall), 64'(0));
        ready_en = 1'b1; i_rem = 3; d_rem = 2; i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 40 && (i_rem != 0 || d_rem != 0); c++) begin
            step();
            if (i_valid) i_rem--;
            if (d_valid) d_rem--;
            i_req = (i_rem != 0);
            d_req = (d_rem != 0);
        end
        check("perf_done", 64'(i_rem + d_rem), 64'(0));
        check("perf_igrant", 64'(perf_igrant), 64'(3));
        check("perf_dgrant", 64'(perf_dgrant), 64'(2));
        check("perf_stall", 64'(perf_stall), 64'(12));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
